// File: rtl/lvalue_stim_pkg.sv
// Shared types and frame layout for the lvalue stimulus assembler.
// Frame length depends on LVAL_STIM_CSUM_EN (adds a trailing XOR checksum byte).
package lvalue_stim_pkg;

    localparam int FRAME_BYTES_BASE = 15;
    localparam int FRAME_BYTES_CSUM = 16;
    localparam int IDX_W            = 5;

    localparam int OFF_CTRL   = 0;
    localparam int OFF_DA     = 1;
    localparam int OFF_NIB    = 5;
    localparam int OFF_STRUCT = 6;
    localparam int OFF_UINT   = 10;
    localparam int OFF_VEC    = 14;

    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, DRAIN} stim_state_t;

    typedef struct packed {
        logic [7:0]  in_vec_packed;
        logic [31:0] in_union_unpacked_val_int;
        logic [31:0] in_struct_val;
        logic [3:0]  in_union_packed_val;
        logic [3:0]  in_slice;
        logic [31:0] in_da_val;
        logic        in_bit;
        logic        enable_assign;
    } stim_rec_t;

    localparam int FV_W = $bits(stim_rec_t);

    // Only bits [1:0] of byte 0 are kept, so byte b>0 starts at bit (b-1)*8+2.
    function automatic int bit_pos(input int byte_idx);
        return (byte_idx == 0) ? 0 : (byte_idx - 1) * 8 + 2;
    endfunction

    function automatic stim_rec_t frame_to_rec(input logic [FV_W-1:0] f);
        stim_rec_t r;
        r.enable_assign             = f[bit_pos(OFF_CTRL)];
        r.in_bit                    = f[bit_pos(OFF_CTRL) + 1];
        r.in_da_val                 = f[bit_pos(OFF_DA) +: 32];
        r.in_slice                  = f[bit_pos(OFF_NIB) +: 4];
        r.in_union_packed_val       = f[bit_pos(OFF_NIB) + 4 +: 4];
        r.in_struct_val             = f[bit_pos(OFF_STRUCT) +: 32];
        r.in_union_unpacked_val_int = f[bit_pos(OFF_UINT) +: 32];
        r.in_vec_packed             = f[bit_pos(OFF_VEC) +: 8];
        return r;
    endfunction

endpackage

// File: rtl/lvalue_stim_csum.sv
// Running XOR accumulator over frame bytes; match_o compares the sum with the
// byte currently on data_i (the checksum byte). Used only with LVAL_STIM_CSUM_EN.
module lvalue_stim_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       acc_i,
    input  logic [7:0] data_i,
    output logic       match_o
);

    logic [7:0] acc_q, acc_d;

    always_comb begin
        acc_d = (clr_i ? 8'h00 : acc_q) ^ (acc_i ? data_i : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= 8'h00;
        else     acc_q <= acc_d;
    end

    assign match_o = (acc_q == data_i);

endmodule

// File: rtl/lvalue_stim_assembler.sv
// Assembles fixed-length byte frames into one stimulus record with valid/ready
// on both sides. Define LVAL_STIM_CSUM_EN to append and verify an XOR checksum byte.
module lvalue_stim_assembler
    import lvalue_stim_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             enable_assign,
    output logic             in_bit,
    output logic [31:0]      in_da_val,
    output logic [3:0]       in_slice,
    output logic [3:0]       in_union_packed_val,
    output logic [31:0]      in_struct_val,
    output logic [31:0]      in_union_unpacked_val_int,
    output logic [7:0]       in_vec_packed,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

`ifdef LVAL_STIM_CSUM_EN
    localparam int FRAME_BYTES = FRAME_BYTES_CSUM;
`else
    localparam int FRAME_BYTES = FRAME_BYTES_BASE;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    stim_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FV_W-1:0]  shadow_q, frame_now;
    stim_rec_t        rec_q;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;
    logic             accept, err_inc, frm_inc, load_rec, csum_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign s_ready = (state_q != PRESENT);
    assign accept  = s_valid && s_ready;

    // Shadow contents with the byte being accepted this cycle merged in, so the
    // final byte of a good frame reaches the record on the same edge.
    always_comb begin
        frame_now = shadow_q;
        for (int b = 0; b < FRAME_BYTES_BASE; b++) begin
            if (idx_q == IDX_W'(b)) begin
                if (b == 0) frame_now[1:0] = s_data[1:0];
                else        frame_now[bit_pos(b) +: 8] = s_data;
            end
        end
    end

`ifdef LVAL_STIM_CSUM_EN
    logic csum_clr, csum_acc;
    assign csum_clr = accept && (state_q == IDLE);
    assign csum_acc = accept && ((state_q == IDLE) ||
                                 ((state_q == COLLECT) && (idx_q != LAST_IDX)));

    lvalue_stim_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (csum_clr),
        .acc_i   (csum_acc),
        .data_i  (s_data),
        .match_o (csum_ok)
    );
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_inc  = 1'b0;
        frm_inc  = 1'b0;
        load_rec = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_last) begin
                        err_inc = 1'b1;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!s_last) begin
                            state_d = DRAIN;
                        end else if (csum_ok) begin
                            state_d  = PRESENT;
                            load_rec = 1'b1;
                        end else begin
                            state_d = IDLE;
                            err_inc = 1'b1;
                        end
                    end else if (s_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        err_inc = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end
            end
            PRESENT: begin
                if (m_ready) begin
                    state_d = IDLE;
                    frm_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rec_q       <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_rec) rec_q       <= frame_to_rec(frame_now);
            if (err_inc)  err_cnt_q   <= sat_inc(err_cnt_q);
            if (frm_inc)  frame_cnt_q <= sat_inc(frame_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && ((state_q == IDLE) || (state_q == COLLECT))) shadow_q <= frame_now;
    end

    assign m_valid                   = (state_q == PRESENT);
    assign enable_assign             = rec_q.enable_assign;
    assign in_bit                    = rec_q.in_bit;
    assign in_da_val                 = rec_q.in_da_val;
    assign in_slice                  = rec_q.in_slice;
    assign in_union_packed_val       = rec_q.in_union_packed_val;
    assign in_struct_val             = rec_q.in_struct_val;
    assign in_union_unpacked_val_int = rec_q.in_union_unpacked_val_int;
    assign in_vec_packed             = rec_q.in_vec_packed;
    assign frame_cnt                 = frame_cnt_q;
    assign err_cnt                   = err_cnt_q;

endmodule

// File: tb/tb_lvalue_stim_assembler.sv
// Scoreboard bench for lvalue_stim_assembler; frames are classified by length
// (and checksum when LVAL_STIM_CSUM_EN is defined) in a byte-level model.
module tb_lvalue_stim_assembler;

`ifdef LVAL_STIM_CSUM_EN
    localparam int FB   = 16;
    localparam bit CSUM = 1'b1;
`else
    localparam int FB   = 15;
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk, rst, s_valid, s_ready, s_last, m_valid, m_ready;
    logic [7:0]  s_data;
    logic        enable_assign, in_bit;
    logic [31:0] in_da_val, in_struct_val, in_union_unpacked_val_int;
    logic [3:0]  in_slice, in_union_packed_val;
    logic [7:0]  in_vec_packed;
    logic [15:0] frame_cnt, err_cnt;

    lvalue_stim_assembler #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .enable_assign(enable_assign), .in_bit(in_bit), .in_da_val(in_da_val),
        .in_slice(in_slice), .in_union_packed_val(in_union_packed_val),
        .in_struct_val(in_struct_val),
        .in_union_unpacked_val_int(in_union_unpacked_val_int),
        .in_vec_packed(in_vec_packed), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    logic [113:0] exp_q[$];
    int exp_frames = 0;
    int exp_errs   = 0;
    bit mr_hold    = 1'b0;
    bit mr_rand    = 1'b0;

    wire [113:0] dut_vec = {in_vec_packed, in_union_unpacked_val_int, in_struct_val,
                            in_union_packed_val, in_slice, in_da_val, in_bit, enable_assign};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [113:0] model_rec(input bq_t f);
        logic [31:0] da, st, ui;
        da = {f[4], f[3], f[2], f[1]};
        st = {f[9], f[8], f[7], f[6]};
        ui = {f[13], f[12], f[11], f[10]};
        return {f[14], ui, st, f[5][7:4], f[5][3:0], da, f[0][1], f[0][0]};
    endfunction

    function automatic logic [7:0] xor15(input bq_t f);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 15; i++) x ^= f[i];
        return x;
    endfunction

    function automatic bq_t gen_good();
        bq_t f;
        for (int i = 0; i < 15; i++) f.push_back(8'($urandom_range(0, 255)));
        if (CSUM) f.push_back(xor15(f));
        return f;
    endfunction

    // Monitor: any cycle with a record on offer is checked against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("m_valid_without_frame", m_valid, 1'b0);
                end else begin
                    chk("record", dut_vec, exp_q[0]);
                    chk("s_ready_in_present", s_ready, 1'b0);
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = mr_hold ? 1'b0 : (mr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        bit acc = 1'b0;
        int n = 0;
        repeat (gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!acc) chk("s_ready_timeout", s_ready, 1'b1);
    endtask

    task automatic send_frame(input bq_t f, input int gapmax);
        bit good = (f.size() == FB);
        if (CSUM && good) good = (xor15(f) == f[15]);
        if (good) begin
            exp_q.push_back(model_rec(f));
            exp_frames++;
        end else begin
            exp_errs++;
        end
        for (int i = 0; i < f.size(); i++)
            send_byte(f[i], (i == f.size() - 1), $urandom_range(0, gapmax));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_frame_cnt"}, frame_cnt, exp_frames);
        chk({tag, "_err_cnt"}, err_cnt, exp_errs);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        exp_errs   = 0;
    endtask

    initial begin
        bq_t f, f2;
        logic [113:0] v0, lit;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        chk("reset_m_valid", m_valid, 1'b0);
        chk("reset_s_ready", s_ready, 1'b1);
        chk("reset_fields", dut_vec, 114'd0);
        check_counters("reset");

        // Directed good frame from the reference example
        f = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
        if (CSUM) f.push_back(xor15(f));
        send_frame(f, 0);
        chk("latency_m_valid", m_valid, 1'b1);
        @(posedge clk);
        #1;
        chk("m_valid_one_cycle", m_valid, 1'b0);
        wait_idle();
        lit = {8'h04, 32'h0000_0001, 32'hDEAD_BEEF, 4'hA, 4'h5, 32'h1234_5678, 1'b1, 1'b1};
        chk("directed_fields_held", dut_vec, lit);
        check_counters("good");

        // Backpressure with the next frame already pushing bytes
        mr_hold = 1'b1;
        f = gen_good();
        send_frame(f, 1);
        f2 = gen_good();
        fork
            send_frame(f2, 0);
            begin
                @(negedge clk);
                v0 = dut_vec;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_fields_stable", dut_vec, v0);
                    chk("bp_m_valid", m_valid, 1'b1);
                    chk("bp_s_ready", s_ready, 1'b0);
                end
                chk("bp_frame_cnt_held", frame_cnt, exp_frames - 2);
                mr_hold = 1'b0;
            end
        join
        wait_idle();
        check_counters("backpressure");

        // Short frame followed by a good one
        f.delete();
        for (int i = 0; i < 7; i++) f.push_back(8'($urandom_range(0, 255)));
        send_frame(f, 1);
        send_frame(gen_good(), 1);
        wait_idle();
        check_counters("short");

        // Long frame followed by a good one
        f.delete();
        for (int i = 0; i < 20; i++) f.push_back(8'($urandom_range(0, 255)));
        send_frame(f, 1);
        send_frame(gen_good(), 1);
        wait_idle();
        check_counters("long");

        // Reset in the middle of a frame
        do_reset();
        f = gen_good();
        for (int i = 0; i < 8; i++) send_byte(f[i], 1'b0, 0);
        do_reset();
        send_frame(gen_good(), 0);
        wait_idle();
        check_counters("reset_mid_frame");

        // Reset while a record is pending
        do_reset();
        mr_hold = 1'b1;
        send_frame(gen_good(), 0);
        chk("pending_m_valid", m_valid, 1'b1);
        do_reset();
        mr_hold = 1'b0;
        chk("after_pending_reset_m_valid", m_valid, 1'b0);
        chk("after_pending_reset_fields", dut_vec, 114'd0);
        check_counters("reset_present");

        if (CSUM) begin
            f = gen_good();
            send_frame(f, 0);
            f[15] = f[15] ^ 8'h01;
            send_frame(f, 0);
            wait_idle();
            check_counters("checksum");
        end

        // Randomized mix of good, short, long and corrupted frames
        mr_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 7);
            f = gen_good();
            if (kind == 0) begin
                int len = $urandom_range(1, FB - 1);
                while (f.size() > len) void'(f.pop_back());
            end else if (kind == 1) begin
                int extra = $urandom_range(1, 6);
                repeat (extra) f.push_back(8'($urandom_range(0, 255)));
            end else if (kind == 2 && CSUM) begin
                f[15] = f[15] ^ 8'(1 << $urandom_range(0, 7));
            end
            send_frame(f, 2);
        end
        wait_idle();
        mr_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_counters("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
